// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Lets NUM_REQ byte-stream requesters (for example ROM-driven message
// printers) share one UART transmitter. Arbitration is round-robin. A
// requester keeps the transmitter for a whole message, until the byte it
// flags as last has been issued. The arbiter talks to each requester with a
// valid/ready handshake. It talks to the UART with a byte plus a one-cycle
// strobe, and watches the UART busy flag.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   req_data     byte from requester i on bits [8i+7:8i]
//   req_valid    requester i has a byte available
//   req_last     byte from requester i ends its message
//   req_ready    combinational; byte from requester i is consumed this cycle
//   tx_data      registered byte to the UART TX, holds between strobes
//   new_tx_data  registered one-cycle strobe, tx_data is valid
//   tx_busy      UART TX busy
//   grant_valid  a requester currently owns the transmitter
//   grant_id     index of the owning requester
//
// Timing with GUARD_CYCLES = G
//   req_valid in IDLE -> SEND one cycle later.
//   The byte and its strobe appear one cycle after req_ready.
//   The next byte of the same message can be strobed G+1 cycles later.
//   The grant is released G+1 cycles after the final strobe.

module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,    // 2..4
  parameter int ID_W          = 2,    // NUM_REQ <= 2**ID_W
  parameter int GUARD_CYCLES  = 2,    // 1..15
  parameter int STALL_TIMEOUT = 1023  // 0 disables the stall timeout
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [ID_W-1:0]      grant_id
);

  localparam int STALL_W = (STALL_TIMEOUT < 2) ? 1 : $clog2(STALL_TIMEOUT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = '1;
  localparam logic [STALL_W-1:0] STALL_LAST =
    (STALL_TIMEOUT == 0) ? '0 : STALL_W'(STALL_TIMEOUT - 1);
  localparam logic [3:0]      GUARD_LOAD = 4'(GUARD_CYCLES);
  localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_valid_d;
  logic [ID_W-1:0]     grant_id_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [7:0]          tx_data_d;
  logic                new_tx_data_d;
  logic                last_q, last_d;
  logic [3:0]          guard_cnt, guard_d;
  logic [STALL_W-1:0]  stall_cnt, stall_d;

  // Signals of the granted requester.
  logic [7:0]          sel_data;
  logic                sel_valid;
  logic                sel_last;
  logic [NUM_REQ-1:0]  grant_onehot;

  // Round-robin scan result.
  logic                win_found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     next_ptr;

  // ---------------------------------------------------------------------------
  // Select the lanes of the current owner.
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from an always_comb gets a default first, so an
  // unassigned path can never infer a latch.
  always_comb begin
    sel_data     = '0;
    sel_valid    = 1'b0;
    sel_last     = 1'b0;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_data        = req_data[8*i +: 8];
        sel_valid       = req_valid[i];
        sel_last        = req_last[i];
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin scan. Start at rr_ptr and wrap modulo NUM_REQ. The first
  // valid requester wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  // The owner that just finished gets the lowest priority next round.
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid;
    grant_id_d    = grant_id;
    rr_ptr_d      = rr_ptr;
    tx_data_d     = tx_data;
    new_tx_data_d = 1'b0;
    last_d        = last_q;
    guard_d       = guard_cnt;
    stall_d       = stall_cnt;
    req_ready     = '0;

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_id_d    = win_id;
          grant_valid_d = 1'b1;
          stall_d       = '0;
          state_d       = SEND;
        end
      end

      SEND: begin
        // A busy UART freezes everything, including the stall timer. A slow
        // UART must never look like a stalled requester.
        if (!tx_busy) begin
          if (sel_valid) begin
            req_ready     = grant_onehot;
            tx_data_d     = sel_data;
            new_tx_data_d = 1'b1;
            last_d        = sel_last;
            guard_d       = GUARD_LOAD;
            stall_d       = '0;
            state_d       = GUARD;
          end else if (STALL_TIMEOUT != 0 && stall_cnt == STALL_LAST) begin
            // The requester went quiet mid-message for too long, so the
            // transmitter is given to the others.
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr;
            stall_d       = '0;
            state_d       = IDLE;
          end else if (stall_cnt != STALL_MAX) begin
            stall_d = stall_cnt + 1'b1;
          end
        end
      end

      GUARD: begin
        // tx_busy is ignored here. The UART raises it a few cycles after the
        // strobe. A mid-message byte goes back to SEND as the count reaches
        // zero, so bytes are GUARD_CYCLES+1 cycles apart. A last byte spends
        // the slot the next SEND would have used at zero. That puts the
        // release on the same cadence.
        if (guard_cnt > 4'd1) begin
          guard_d = guard_cnt - 4'd1;
        end else if (guard_cnt == 4'd1 && last_q) begin
          guard_d = '0;
        end else begin
          guard_d = '0;
          if (last_q) begin
            grant_valid_d = 1'b0;
            rr_ptr_d      = next_ptr;
            stall_d       = '0;
            state_d       = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end

      default: begin
        grant_valid_d = 1'b0;
        state_d       = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples the values from before the edge, whatever the statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      last_q      <= 1'b0;
      guard_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
      rr_ptr      <= rr_ptr_d;
      tx_data     <= tx_data_d;
      new_tx_data <= new_tx_data_d;
      last_q      <= last_d;
      guard_cnt   <= guard_d;
      stall_cnt   <= stall_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (NUM_REQ=4, GUARD_CYCLES=2,
// STALL_TIMEOUT=8). Each requester lane is a queue of {last, byte} entries.
// A lane pops its head once the arbiter has consumed it. A monitor logs every
// strobe and every new grant with its cycle number. The directed steps check
// those logs against hand-computed orders and timings.

module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int ID_W          = 2;
  localparam int GUARD_CYCLES  = 2;
  localparam int STALL_TIMEOUT = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .GUARD_CYCLES (GUARD_CYCLES),
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .new_tx_data(new_tx_data),
    .tx_busy    (tx_busy),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              cyc;
    logic [7:0]      data;
    logic [ID_W-1:0] id;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gv_fall_cyc = -1;
  int   bad_strobe = 0;
  logic prev_strobe = 1'b0;
  logic prev_gv = 1'b0;
  ev_t  mon_ev;
  ev_t  strobe_log[$];
  ev_t  grant_log[$];

  logic [8:0]         lane_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] hold;

  logic [7:0] hi_exp[3]     = '{8'h68, 8'h69, 8'h0A};
  int         cont_ids[4]   = '{0, 2, 0, 2};
  logic [7:0] cont_base[4]  = '{8'hA0, 8'hC0, 8'hB0, 8'hD0};
  int         rr_ids[5]     = '{0, 1, 2, 3, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log strobes and grant edges. Also flag a strobe with no grant or
  // a strobe on two consecutive cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0;
      prev_gv     = 1'b0;
    end else begin
      if (new_tx_data) begin
        if (prev_strobe || !grant_valid) bad_strobe++;
        mon_ev.cyc  = cyc;
        mon_ev.data = tx_data;
        mon_ev.id   = grant_id;
        strobe_log.push_back(mon_ev);
      end
      if (grant_valid && !prev_gv) begin
        mon_ev.cyc  = cyc;
        mon_ev.data = 8'h00;
        mon_ev.id   = grant_id;
        grant_log.push_back(mon_ev);
      end
      if (!grant_valid && prev_gv) gv_fall_cyc = cyc;
      prev_strobe = new_tx_data;
      prev_gv     = grant_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes();
    logic [8:0] e;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (lane_q[i].size() != 0 && !hold[i]) begin
        e                  = lane_q[i][0];
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // One clock. A lane whose ready was high before the edge had its head byte
  // consumed, so it moves on to its next byte.
  task automatic tick();
    logic [NUM_REQ-1:0] seen;
    seen = req_ready;
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++)
      if (seen[i] && lane_q[i].size() != 0) void'(lane_q[i].pop_front());
    drive_lanes();
    #1;
  endtask

  function automatic bit lanes_empty();
    for (int i = 0; i < NUM_REQ; i++)
      if (lane_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(lanes_empty() && !grant_valid) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, {31'b0, lanes_empty() && !grant_valid}, 32'd1);
  endtask

  task automatic wait_strobes(input string tag, input int count, input int budget);
    int n;
    n = 0;
    while (strobe_log.size() < count && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_strobe_seen"}, strobe_log.size(), count);
  endtask

  task automatic clear_logs();
    strobe_log.delete();
    grant_log.delete();
  endtask

  initial begin
    int c0, s, r, bfall, n, rdy_bad, strb_bad, gv_bad;

    rst_n     = 1'b0;
    req_data  = '0;
    req_valid = '1;
    req_last  = '0;
    tx_busy   = 1'b0;
    hold      = '0;

    // ---- Reset state (req_valid high on purpose: ready must still be 0) ----
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_new_tx_data", new_tx_data, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    req_valid = '0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // ---- Single requester: lane 1 sends "hi\n" ----
    clear_logs();
    lane_q[1].push_back({1'b0, 8'h68});
    lane_q[1].push_back({1'b0, 8'h69});
    lane_q[1].push_back({1'b1, 8'h0A});
    drive_lanes();
    c0 = cyc;
    #1;
    run_until_idle("hi", 60);
    check("hi_count", strobe_log.size(), 3);
    if (strobe_log.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("hi_data%0d", k), strobe_log[k].data, hi_exp[k]);
        check($sformatf("hi_id%0d", k), strobe_log[k].id, 1);
        check($sformatf("hi_cyc%0d", k), strobe_log[k].cyc - c0, 2 + 3*k);
      end
    end
    if (grant_log.size() >= 1) check("hi_grant_cyc", grant_log[0].cyc - c0, 1);
    check("hi_release_cyc", gv_fall_cyc - c0, 11);
    check("hi_tx_data_hold", tx_data, 8'h0A);

    // ---- rr_ptr is 2 now: lanes 0 and 3 together -> 3 wins, then 0 ----
    clear_logs();
    lane_q[0].push_back({1'b1, 8'h30});
    lane_q[3].push_back({1'b1, 8'h33});
    drive_lanes();
    #1;
    run_until_idle("rr", 60);
    check("rr_count", strobe_log.size(), 2);
    if (strobe_log.size() >= 2) begin
      check("rr_first_id", strobe_log[0].id, 3);
      check("rr_first_data", strobe_log[0].data, 8'h33);
      check("rr_second_id", strobe_log[1].id, 0);
      check("rr_second_data", strobe_log[1].data, 8'h30);
    end

    // ---- Contention: lanes 0 and 2 valid from reset, two messages each ----
    rst_n = 1'b0;
    #1;
    for (int b = 0; b < 4; b++) lane_q[0].push_back({b == 3, 8'hA0 + 8'(b)});
    for (int b = 0; b < 4; b++) lane_q[0].push_back({b == 3, 8'hB0 + 8'(b)});
    for (int b = 0; b < 4; b++) lane_q[2].push_back({b == 3, 8'hC0 + 8'(b)});
    for (int b = 0; b < 4; b++) lane_q[2].push_back({b == 3, 8'hD0 + 8'(b)});
    drive_lanes();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    run_until_idle("cont", 200);
    check("cont_count", strobe_log.size(), 16);
    if (strobe_log.size() >= 16) begin
      for (int m = 0; m < 4; m++) begin
        for (int b = 0; b < 4; b++) begin
          check($sformatf("cont_id_m%0d_b%0d", m, b), strobe_log[4*m+b].id, cont_ids[m]);
          check($sformatf("cont_data_m%0d_b%0d", m, b), strobe_log[4*m+b].data,
                cont_base[m] + 8'(b));
        end
      end
    end

    // ---- Busy backpressure: lane 1, tx_busy high 100 cycles after strobe 1 ----
    clear_logs();
    lane_q[1].push_back({1'b0, 8'h11});
    lane_q[1].push_back({1'b1, 8'h12});
    drive_lanes();
    #1;
    wait_strobes("busy", 1, 20);
    tx_busy  = 1'b1;
    rdy_bad  = 0;
    strb_bad = 0;
    gv_bad   = 0;
    repeat (100) begin
      tick();
      if (req_ready != '0) rdy_bad++;
      if (new_tx_data) strb_bad++;
      if (!grant_valid) gv_bad++;
    end
    check("busy_ready_low", rdy_bad, 0);
    check("busy_no_strobe", strb_bad, 0);
    check("busy_grant_kept", gv_bad, 0);
    tx_busy = 1'b0;
    bfall   = cyc;
    #1;
    check("busy_ready_after", req_ready, 4'b0010);
    run_until_idle("busy", 40);
    check("busy_count", strobe_log.size(), 2);
    if (strobe_log.size() >= 2) begin
      check("busy_second_cyc", strobe_log[1].cyc - bfall, 1);
      check("busy_second_data", strobe_log[1].data, 8'h12);
    end

    // ---- Stall timeout: lane 3 goes quiet after byte 1, lane 0 waits ----
    clear_logs();
    lane_q[3].push_back({1'b0, 8'h31});
    lane_q[3].push_back({1'b0, 8'h32});
    lane_q[3].push_back({1'b1, 8'h33});
    drive_lanes();
    #1;
    wait_strobes("stall", 1, 20);
    s = (strobe_log.size() >= 1) ? strobe_log[0].cyc : cyc;
    hold[3] = 1'b1;
    lane_q[0].push_back({1'b1, 8'h55});
    drive_lanes();
    #1;
    n = 0;
    while (grant_valid && n < 40) begin
      tick();
      n++;
    end
    check("stall_released", grant_valid, 0);
    check("stall_release_cyc", gv_fall_cyc - s, 10);
    lane_q[3].delete();
    hold[3] = 1'b0;
    drive_lanes();
    #1;
    run_until_idle("stall", 40);
    check("stall_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      check("stall_next_id", grant_log[1].id, 0);
      check("stall_next_cyc", grant_log[1].cyc - s, 11);
    end
    if (strobe_log.size() >= 2) begin
      check("stall_next_data", strobe_log[1].data, 8'h55);
      check("stall_next_strobe_cyc", strobe_log[1].cyc - s, 12);
    end

    // ---- Reset mid-message: lane 1, async reset during the first strobe ----
    clear_logs();
    lane_q[1].push_back({1'b0, 8'h71});
    lane_q[1].push_back({1'b0, 8'h72});
    lane_q[1].push_back({1'b1, 8'h73});
    drive_lanes();
    #1;
    wait_strobes("rstmid", 1, 20);
    check("rstmid_strobe_before", new_tx_data, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_strobe_cleared", new_tx_data, 0);
    check("rstmid_grant_cleared", grant_valid, 0);
    check("rstmid_tx_data_cleared", tx_data, 0);
    check("rstmid_ready_cleared", req_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    clear_logs();
    run_until_idle("rstmid", 40);
    if (grant_log.size() >= 1) begin
      check("rstmid_regrant_id", grant_log[0].id, 1);
      check("rstmid_regrant_cyc", grant_log[0].cyc - r, 1);
    end
    check("rstmid_count", strobe_log.size(), 2);
    if (strobe_log.size() >= 2) begin
      check("rstmid_first_data", strobe_log[0].data, 8'h72);
      check("rstmid_first_cyc", strobe_log[0].cyc - r, 2);
      check("rstmid_second_data", strobe_log[1].data, 8'h73);
    end

    // ---- All four lanes valid with 1-byte messages: order 0,1,2,3,0 ----
    rst_n = 1'b0;
    #1;
    lane_q[0].push_back({1'b1, 8'hE0});
    lane_q[0].push_back({1'b1, 8'hE4});
    lane_q[1].push_back({1'b1, 8'hE1});
    lane_q[2].push_back({1'b1, 8'hE2});
    lane_q[3].push_back({1'b1, 8'hE3});
    drive_lanes();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    run_until_idle("all4", 120);
    check("all4_strobes", strobe_log.size(), 5);
    check("all4_grants", grant_log.size(), 5);
    if (strobe_log.size() >= 5 && grant_log.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("all4_grant_id%0d", k), grant_log[k].id, rr_ids[k]);
        check($sformatf("all4_strobe_id%0d", k), strobe_log[k].id, rr_ids[k]);
        check($sformatf("all4_data%0d", k), strobe_log[k].data, 8'hE0 + 8'(k));
      end
      check("all4_spacing", strobe_log[1].cyc - strobe_log[0].cyc, 5);
    end

    check("no_bad_strobe", bad_strobe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
